phy_reg_free_list: RTL
======================

PHY_REG_FREE_LIST -- requirements
Module: phy_reg_free_list

Interface
REQ-001 The block SHALL have parameter NUM_PHY, default 128, giving the number of physical registers and the depth of the free-list ring.
REQ-002 The block SHALL have parameter NUM_ARCH, default 32, giving the number of physical registers pre-mapped to architectural registers at reset.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port alloc_req_i, input, 1 bit: rename requests one free physical register this cycle.
REQ-006 The block SHALL have port alloc_gnt_o, output, 1 bit: the allocation is granted this cycle (combinational).
REQ-007 The block SHALL have port alloc_id_o, output, 8 bits (PhyRegisterId_T): bit7 is valid, bits[6:0] are the physical register id.
REQ-008 The block SHALL have port release_valid_i, input, 1 bit: commit frees one old physical register.
REQ-009 The block SHALL have port release_id_i, input, 7 bits: the physical register id being freed.
REQ-010 The block SHALL have port commit_alloc_i, input, 1 bit: the oldest speculative allocation became architectural.
REQ-011 The block SHALL have port flush_i, input, 1 bit: mispredict or exception; discard all speculative allocations.
REQ-012 The block SHALL have port free_count_o, output, 8 bits: registered count of speculatively free entries.
REQ-013 The block SHALL have port err_o, output, 1 bit: sticky protocol-violation flag.

Function
REQ-014 Storage SHALL be a NUM_PHY-entry ring of 7-bit ids with 8-bit pointers (bit7 = wrap): spec_head, arch_head and tail.
REQ-015 free_count SHALL equal tail - spec_head (mod 256) and SHALL range 0..NUM_PHY.
REQ-016 alloc_gnt_o SHALL equal alloc_req_i & (free_count != 0) & !flush_i.
REQ-017 alloc_id_o SHALL equal {alloc_gnt_o, ring[spec_head[6:0]]}; bit7 SHALL be 0 whenever there is no grant.
REQ-018 On grant, spec_head SHALL increment by 1 at the next edge; allocation latency is 0 cycles and throughput is 1 per cycle.
REQ-019 When release_valid_i is high and total occupancy (tail - arch_head) < NUM_PHY, the block SHALL write release_id_i to ring[tail[6:0]] and increment tail.
REQ-020 A release at total occupancy == NUM_PHY SHALL be dropped and SHALL set err_o.
REQ-021 A release in cycle N SHALL NOT be allocatable before cycle N+1; there is no same-cycle bypass.
REQ-022 When commit_alloc_i is high and arch_head != spec_head, arch_head SHALL increment by 1.
REQ-023 When commit_alloc_i is high and arch_head == spec_head, the commit SHALL be ignored and SHALL set err_o.
REQ-024 On flush_i, spec_head SHALL load the post-update arch_head, including any same-cycle commit_alloc_i increment.
REQ-025 A release in the same cycle as flush_i SHALL still be applied.
REQ-026 A commit in the same cycle as an allocation SHALL be legal; arch_head SHALL be compared against spec_head before that cycle's increment.
REQ-027 Pointer wrap SHALL be seamless: index = ptr[6:0], and the full/empty distinction comes from bit7.
REQ-028 free_count_o SHALL be a register updated each edge from the next-state pointers.

Reset
REQ-029 On rst, ring[i] SHALL be loaded with NUM_ARCH+i for i in 0..NUM_PHY-NUM_ARCH-1; remaining entries are don't-care.
REQ-030 On rst: spec_head = arch_head = 0, tail = NUM_PHY-NUM_ARCH (96), free_count_o = 96, err_o = 0.
REQ-031 alloc_gnt_o SHALL be 0 during any cycle in which rst is high.
REQ-032 rst asserted mid-operation SHALL override all concurrent alloc, release, commit and flush activity.

Verification
REQ-033 Reset, then alloc_req_i high for 3 cycles -> alloc_id_o = 0xA0, 0xA1, 0xA2; free_count_o = 93.
REQ-034 Allocate 96 consecutive times -> the 97th cycle has alloc_gnt_o = 0, alloc_id_o[7] = 0, free_count_o = 0.
REQ-035 Allocate 5, commit_alloc 2, flush -> next cycle free_count_o = 94 and the next grant returns id 34.
REQ-036 Drain to empty, then release id 7 together with alloc_req_i -> no grant that cycle; next cycle the grant returns id 7.
REQ-037 At reset, commit_alloc_i with no allocation -> err_o = 1 and stays 1 until rst.
REQ-038 Release 32 with no allocation (total occupancy 128), then release id 5 -> dropped, err_o = 1, free_count_o remains 128.

Source files
------------

// File: rtl/phy_reg_free_list.sv
// Physical register free list: a ring of free ids with speculative and architectural
// heads, so a flush can return all speculatively allocated registers in one cycle.
module phy_reg_free_list #(
  parameter int unsigned NUM_PHY  = 128,
  parameter int unsigned NUM_ARCH = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       alloc_req_i,
  output logic       alloc_gnt_o,
  output logic [7:0] alloc_id_o,
  input  logic       release_valid_i,
  input  logic [6:0] release_id_i,
  input  logic       commit_alloc_i,
  input  logic       flush_i,
  output logic [7:0] free_count_o,
  output logic       err_o
);

  localparam logic [7:0] InitTail = 8'(NUM_PHY - NUM_ARCH);
  localparam logic [7:0] RingSize = 8'(NUM_PHY);

  logic [6:0] r_ring [NUM_PHY];
  logic [7:0] r_spec_head;
  logic [7:0] r_arch_head;
  logic [7:0] r_tail;
  logic [7:0] r_free_count;
  logic       r_err;

  logic       w_gnt;
  logic [7:0] w_occ;
  logic       w_rel_ok;
  logic       w_rel_drop;
  logic       w_commit_ok;
  logic       w_commit_bad;
  logic [7:0] w_spec_head_d;
  logic [7:0] w_arch_head_d;
  logic [7:0] w_tail_d;
  logic       w_err_d;

  // r_free_count always equals r_tail - r_spec_head, so it doubles as the empty test.
  assign w_gnt       = alloc_req_i & (r_free_count != 8'd0) & ~flush_i & ~rst;
  assign alloc_gnt_o = w_gnt;
  assign alloc_id_o  = {w_gnt, r_ring[r_spec_head[6:0]]};

  assign free_count_o = r_free_count;
  assign err_o        = r_err;

  // Occupancy counts every ring entry not yet architecturally consumed.
  assign w_occ        = r_tail - r_arch_head;
  assign w_rel_ok     = release_valid_i & (w_occ < RingSize);
  assign w_rel_drop   = release_valid_i & ~(w_occ < RingSize);
  assign w_commit_ok  = commit_alloc_i & (r_arch_head != r_spec_head);
  assign w_commit_bad = commit_alloc_i & (r_arch_head == r_spec_head);

  always_comb begin
    w_arch_head_d = r_arch_head;
    w_tail_d      = r_tail;
    w_spec_head_d = r_spec_head;
    w_err_d       = r_err | w_rel_drop | w_commit_bad;
    if (w_commit_ok) begin
      w_arch_head_d = r_arch_head + 8'd1;
    end
    if (w_rel_ok) begin
      w_tail_d = r_tail + 8'd1;
    end
    // A flush rewinds to the committed head, including this cycle's commit.
    if (flush_i) begin
      w_spec_head_d = w_arch_head_d;
    end else if (w_gnt) begin
      w_spec_head_d = r_spec_head + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_spec_head  <= 8'd0;
      r_arch_head  <= 8'd0;
      r_tail       <= InitTail;
      r_free_count <= InitTail;
      r_err        <= 1'b0;
      for (int unsigned i = 0; i < NUM_PHY - NUM_ARCH; i++) begin
        r_ring[7'(i)] <= 7'(NUM_ARCH + i);
      end
    end else begin
      r_spec_head  <= w_spec_head_d;
      r_arch_head  <= w_arch_head_d;
      r_tail       <= w_tail_d;
      r_free_count <= w_tail_d - w_spec_head_d;
      r_err        <= w_err_d;
      if (w_rel_ok) begin
        r_ring[r_tail[6:0]] <= release_id_i;
      end
    end
  end

endmodule
